// File: rtl/tl_mem_requester.sv
// rtl/tl_mem_requester.sv - single-outstanding TileLink memory requester with timeout and alignment check
// Optional transaction counters: define TL_MEMREQ_STATS_EN.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_mem_requester #(
   parameter int ADDR_BITS      = `TL_ADDR_BITS,
   parameter int DATA_BYTES     = `TL_DATA_BYTES,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_BITS-1:0]    cmd_addr,
   input  logic [DATA_BYTES*8-1:0] cmd_data,
   input  logic [DATA_BYTES-1:0]   cmd_mask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_BYTES*8-1:0] rsp_data,
   output logic                    rsp_error,
   output logic                    write_valid,
   output logic [ADDR_BITS-1:0]    write_addr,
   output logic [DATA_BYTES*8-1:0] write_data,
   output logic [DATA_BYTES-1:0]   write_mask,
   input  logic                    write_ready,
   output logic                    read_valid,
   output logic [ADDR_BITS-1:0]    read_addr,
   input  logic [DATA_BYTES*8-1:0] read_data,
   input  logic                    read_data_valid
`ifdef TL_MEMREQ_STATS_EN
   ,
   output logic [15:0]             rd_count,
   output logic [15:0]             wr_count,
   output logic [15:0]             err_count
`endif
);

   localparam int DW       = DATA_BYTES * 8;
   localparam int OFF_BITS = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q;
   logic                  cmd_ready_q;
   logic                  write_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [DW-1:0]         data_q;
   logic [DATA_BYTES-1:0] mask_q;
   logic                  read_valid_q;
   logic                  write_valid_q;
   logic [7:0]            cnt_q;
   logic                  rsp_valid_q;
   logic                  rsp_write_q;
   logic [DW-1:0]         rsp_data_q;
   logic                  rsp_error_q;

   logic cmd_misaligned;
   logic wait_done;

   // Byte-sized data has no offset bits, so it can never be misaligned.
   assign cmd_misaligned = (DATA_BYTES > 1) && (cmd_addr[OFF_BITS-1:0] != '0);
   assign wait_done      = write_q ? write_ready : read_data_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         mask_q        <= '0;
         read_valid_q  <= 1'b0;
         write_valid_q <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_error_q   <= 1'b0;
      end else begin
         read_valid_q  <= 1'b0;
         write_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  write_q     <= cmd_write;
                  addr_q      <= cmd_addr;
                  data_q      <= cmd_data;
                  mask_q      <= cmd_mask;
                  if (cmd_misaligned) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_write_q <= cmd_write;
                     rsp_data_q  <= '0;
                     rsp_error_q <= 1'b1;
                  end else begin
                     state_q       <= ISSUE;
                     read_valid_q  <= !cmd_write;
                     write_valid_q <= cmd_write;
                  end
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               cnt_q   <= '0;
            end
            WAIT: begin
               // Completion takes priority over the timeout in the same cycle.
               if (wait_done) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= write_q;
                  rsp_data_q  <= write_q ? '0 : read_data;
                  rsp_error_q <= 1'b0;
               end else if (cnt_q == LIMIT) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= write_q;
                  rsp_data_q  <= '0;
                  rsp_error_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  cnt_q       <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_write   = rsp_write_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_error   = rsp_error_q;
   assign write_valid = write_valid_q;
   assign write_addr  = addr_q;
   assign write_data  = data_q;
   assign write_mask  = mask_q;
   assign read_valid  = read_valid_q;
   assign read_addr   = addr_q;

`ifdef TL_MEMREQ_STATS_EN
   logic [15:0] rd_count_q;
   logic [15:0] wr_count_q;
   logic [15:0] err_count_q;
   logic        rsp_fire;

   assign rsp_fire = rsp_valid_q && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         err_count_q <= '0;
      end else if (rsp_fire) begin
         if (rsp_error_q) begin
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
         end else if (rsp_write_q) begin
            if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
         end else begin
            if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
         end
      end
   end

   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_tl_mem_requester.sv
// tb/tb_tl_mem_requester.sv - randomized bench for tl_mem_requester against a transaction-level model
`timescale 1ns/1ps
module tb_tl_mem_requester;

   localparam int AW = 32;
   localparam int DB = 8;
   localparam int DW = 64;
   localparam int T  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [DB-1:0] cmd_mask = '0;
   logic          cmd_ready;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          rsp_write;
   logic [DW-1:0] rsp_data;
   logic          rsp_error;
   logic          write_valid;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic [DB-1:0] write_mask;
   logic          write_ready = 1'b0;
   logic          read_valid;
   logic [AW-1:0] read_addr;
   logic [DW-1:0] read_data = '0;
   logic          read_data_valid = 1'b0;
`ifdef TL_MEMREQ_STATS_EN
   logic [15:0]   rd_count, wr_count, err_count;
`endif

   tl_mem_requester #(.ADDR_BITS(AW), .DATA_BYTES(DB), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_data(rsp_data), .rsp_error(rsp_error),
      .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
      .write_mask(write_mask), .write_ready(write_ready),
      .read_valid(read_valid), .read_addr(read_addr), .read_data(read_data),
      .read_data_valid(read_data_valid)
`ifdef TL_MEMREQ_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: untouched words read as AA.. in the top byte and the word index below.
   logic [63:0] mem [logic [31:0]];

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 64'hAA00_0000_0000_0000 | 64'(a >> 3);
   endfunction

   task automatic mem_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] v;
      v = mem_rd(a);
      for (int i = 0; i < 8; i++) if (m[i]) v[i*8 +: 8] = d[i*8 +: 8];
      mem[a] = v;
   endtask

   // Expected transaction, shared with the compare process.
   int          cyc = 0;
   bit          mute = 1'b1;
   bit          txn_active = 1'b0;
   int          hs_cyc = 0;
   int          lat = 0;
   int          exp_req = 0;
   bit          e_write = 1'b0;
   logic [31:0] e_addr = '0;
   logic [63:0] e_data = '0;
   logic [7:0]  e_mask = '0;
   logic [63:0] e_rdata = '0;
   bit          e_err = 1'b0;
   int          first_rsp_rel = -1;
   logic [63:0] last_rsp_data = '0;
   logic        last_rsp_err = 1'b0;
   int          st_rd = 0, st_wr = 0, st_err = 0;

   // Responder knobs.
   int resp_delay = 0;
   bit inject_wrong = 1'b0;
   int gen = 0;

   initial begin : compare
      int rel;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mute) begin
            if (!txn_active) begin
               chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
               chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
               chk("idle_read_valid", 64'(read_valid), 64'd0);
               chk("idle_write_valid", 64'(write_valid), 64'd0);
            end else begin
               rel = cyc - hs_cyc;
               chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
               chk("read_valid", 64'(read_valid), 64'(rel == 1 && exp_req == 1));
               chk("write_valid", 64'(write_valid), 64'(rel == 1 && exp_req == 2));
               if (exp_req == 1 && rel < lat) chk("read_addr", 64'(read_addr), 64'(e_addr));
               if (exp_req == 2 && rel < lat) begin
                  chk("write_addr", 64'(write_addr), 64'(e_addr));
                  chk("write_data", write_data, e_data);
                  chk("write_mask", 64'(write_mask), 64'(e_mask));
               end
               chk("rsp_valid", 64'(rsp_valid), 64'(rel >= lat));
               if (rsp_valid && first_rsp_rel < 0) first_rsp_rel = rel;
               if (rel >= lat) begin
                  chk("rsp_write", 64'(rsp_write), 64'(e_write));
                  chk("rsp_data", rsp_data, e_rdata);
                  chk("rsp_error", 64'(rsp_error), 64'(e_err));
               end
            end
         end
      end
   end

   // Memory responder: completion D+1 cycles after the request cycle, optional wrong-type pulse.
   initial begin : responder
      bit          is_rd;
      logic [31:0] ra;
      int          kdone;
      int          g;
      forever begin
         @(negedge clk);
         if (!mute && (read_valid || write_valid)) begin
            is_rd = read_valid;
            ra    = read_addr;
            kdone = (resp_delay < 0) ? T + 3 : resp_delay + 1;
            g     = gen;
            for (int k = 1; k <= kdone; k++) begin
               @(negedge clk);
               read_data_valid = 1'b0;
               write_ready     = 1'b0;
               read_data       = {$urandom, $urandom};
               if (g != gen) break;
               if (k == kdone) begin
                  if (is_rd) begin
                     read_data_valid = 1'b1;
                     read_data       = mem_rd(ra);
                  end else begin
                     write_ready = 1'b1;
                  end
               end else if (inject_wrong && k == 1) begin
                  if (is_rd) write_ready = 1'b1;
                  else read_data_valid = 1'b1;
               end
            end
            @(negedge clk);
            read_data_valid = 1'b0;
            write_ready     = 1'b0;
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_write"}, 64'(rsp_write), 64'd0);
      chk({tag, "_rsp_data"}, rsp_data, 64'd0);
      chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
      chk({tag, "_read_valid"}, 64'(read_valid), 64'd0);
      chk({tag, "_write_valid"}, 64'(write_valid), 64'd0);
      chk({tag, "_read_addr"}, 64'(read_addr), 64'd0);
      chk({tag, "_write_data"}, write_data, 64'd0);
      chk({tag, "_write_mask"}, 64'(write_mask), 64'd0);
`ifdef TL_MEMREQ_STATS_EN
      chk({tag, "_rd_count"}, 64'(rd_count), 64'd0);
      chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
      chk({tag, "_err_count"}, 64'(err_count), 64'd0);
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Runs one command from a point 1ns after a rising edge; abort_at > 0 resets mid-flight.
   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] mask, input int delay, input bit wrong,
                         input int hold, input int abort_at);
      bit misal, tmo;
      misal   = (addr[2:0] != 3'd0);
      tmo     = !misal && (delay < 0 || delay + 1 > T);
      e_write = wr;
      e_addr  = addr;
      e_data  = data;
      e_mask  = mask;
      exp_req = misal ? 0 : (wr ? 2 : 1);
      if (misal) lat = 1;
      else if (tmo) lat = T + 2;
      else lat = delay + 3;
      e_err   = misal || tmo;
      e_rdata = (e_err || wr) ? 64'd0 : mem_rd(addr);
      if (!e_err && wr && abort_at == 0) mem_wr(addr, data, mask);
      resp_delay   = delay;
      inject_wrong = wrong;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_mask  = mask;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_data  = {$urandom, $urandom};
      cmd_mask  = 8'($urandom);
      hs_cyc        = cyc;
      first_rsp_rel = -1;
      txn_active    = 1'b1;
      if (abort_at > 0) begin
         repeat (abort_at) @(posedge clk);
         #1;
         rst_n = 1'b0;
         gen++;
         mute       = 1'b1;
         txn_active = 1'b0;
         st_rd = 0; st_wr = 0; st_err = 0;
         #1;
         check_zero("rst_mid");
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         @(posedge clk);
         #1;
         chk("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
         mute = 1'b0;
         return;
      end
      repeat (lat + hold - 1) @(posedge clk);
      #1;
      last_rsp_data = rsp_data;
      last_rsp_err  = rsp_error;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready  = 1'b0;
      txn_active = 1'b0;
      if (e_err) st_err++;
      else if (wr) st_wr++;
      else st_rd++;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] a;
      int d;
      bit w;
      #2;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_release_cmd_ready", 64'(cmd_ready), 64'd1);
      mute = 1'b0;

      do_cmd(1'b0, 32'h40, 64'd0, 8'h00, 5, 1'b0, 0, 0);
      chk("lit_read40_data", last_rsp_data, 64'hAA00_0000_0000_0008);
      chk("lit_read40_err", 64'(last_rsp_err), 64'd0);
      chk("lit_read40_latency", 64'(first_rsp_rel), 64'd8);
      idle(3);

      do_cmd(1'b1, 32'h40, 64'h1122_3344_5566_7788, 8'h0F, 3, 1'b0, 0, 0);
      chk("lit_write40_data", last_rsp_data, 64'd0);
      chk("lit_write40_err", 64'(last_rsp_err), 64'd0);
      idle(3);
      do_cmd(1'b0, 32'h40, 64'd0, 8'h00, 4, 1'b1, 0, 0);
      chk("lit_readback40", last_rsp_data, 64'hAA00_0000_5566_7788);
      idle(3);

      do_cmd(1'b0, 32'h48, 64'd0, 8'h00, -1, 1'b0, 5, 0);
      chk("lit_timeout_err", 64'(last_rsp_err), 64'd1);
      chk("lit_timeout_data", last_rsp_data, 64'd0);
      chk("lit_timeout_latency", 64'(first_rsp_rel), 64'(T + 2));
      idle(3);
      do_cmd(1'b0, 32'h48, 64'd0, 8'h00, 2, 1'b0, 0, 0);
      chk("lit_after_timeout", last_rsp_data, 64'hAA00_0000_0000_0009);
      idle(3);

      do_cmd(1'b0, 32'h44, 64'd0, 8'h00, 2, 1'b0, 0, 0);
      chk("lit_misaligned_err", 64'(last_rsp_err), 64'd1);
      chk("lit_misaligned_latency", 64'(first_rsp_rel), 64'd1);
      idle(3);

      do_cmd(1'b0, 32'h80, 64'd0, 8'h00, 1, 1'b0, 10, 0);
      idle(3);
      do_cmd(1'b0, 32'h88, 64'd0, 8'h00, T - 1, 1'b0, 0, 0);
      chk("lit_limit_completion_err", 64'(last_rsp_err), 64'd0);
      idle(3);
      do_cmd(1'b0, 32'h90, 64'd0, 8'h00, T, 1'b0, 2, 0);
      chk("lit_limit_plus1_err", 64'(last_rsp_err), 64'd1);
      idle(3);
      do_cmd(1'b1, 32'h98, 64'hDEAD_BEEF_0BAD_F00D, 8'hF0, 4, 1'b1, 0, 0);
      idle(3);

      do_cmd(1'b0, 32'h100, 64'd0, 8'h00, 20, 1'b0, 0, 5);
      idle(3);

      for (int n = 0; n < 150; n++) begin
         w = 1'($urandom);
         a = 32'($urandom_range(0, 31)) << 3;
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 7));
         case ($urandom_range(0, 9))
            0:       d = w ? 31 : -1;
            1:       d = $urandom_range(29, w ? 31 : 33);
            default: d = $urandom_range(0, 12);
         endcase
         do_cmd(w, a, {$urandom, $urandom}, 8'($urandom), d, 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 4), 0);
         idle($urandom_range(3, 5));
      end

`ifdef TL_MEMREQ_STATS_EN
      chk("stats_rd", 64'(rd_count), 64'(st_rd));
      chk("stats_wr", 64'(wr_count), 64'(st_wr));
      chk("stats_err", 64'(err_count), 64'(st_err));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
